// File: rtl/alu_seq_ctrl_pkg.sv
// Shared opcodes, flag bit positions and controller state encoding for the alu
// sequencing controller.
package alu_seq_ctrl_pkg;

    localparam int unsigned OPW  = 5;
    localparam int unsigned SHW  = 5;
    localparam int unsigned FLGW = 5;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00000;
    localparam logic [OPW-1:0] OP_COMP = 5'b00001;
    localparam logic [OPW-1:0] OP_AND  = 5'b00010;
    localparam logic [OPW-1:0] OP_OR   = 5'b00011;
    localparam logic [OPW-1:0] OP_XOR  = 5'b00100;
    localparam logic [OPW-1:0] OP_NOR  = 5'b00101;
    localparam logic [OPW-1:0] OP_SLL  = 5'b00110;
    localparam logic [OPW-1:0] OP_SRL  = 5'b00111;
    localparam logic [OPW-1:0] OP_SRA  = 5'b01000;
    localparam logic [OPW-1:0] OP_LUI  = 5'b01001;
    localparam logic [OPW-1:0] OP_PASS = 5'b01010;
    localparam logic [OPW-1:0] OP_BLTZ = 5'b01011;
    localparam logic [OPW-1:0] OP_BZ   = 5'b01100;
    localparam logic [OPW-1:0] OP_BNZ  = 5'b01101;
    localparam logic [OPW-1:0] OP_BCY  = 5'b01110;
    localparam logic [OPW-1:0] OP_BNCY = 5'b01111;
    localparam logic [OPW-1:0] OP_DIFF = 5'b10000;

    localparam int unsigned FLG_NEG = 0;
    localparam int unsigned FLG_Z   = 1;
    localparam int unsigned FLG_NZ  = 2;
    localparam int unsigned FLG_NCY = 3;
    localparam int unsigned FLG_CY  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Op request / result handshake bundle between a requester and the controller.
interface alu_seq_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    import alu_seq_ctrl_pkg::*;

    logic            op_valid;
    logic            op_ready;
    logic [OPW-1:0]  op_code;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [SHW-1:0]  op_shamt;
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res_data;
    logic            br_taken;

    modport master (
        output op_valid, op_code, op_a, op_b, op_shamt, res_ready,
        input  op_ready, res_valid, res_data, br_taken
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b, op_shamt, res_ready,
        output op_ready, res_valid, res_data, br_taken
    );

endinterface

// File: rtl/alu_seq_ctrl_diff_scanner.sv
// Multi-cycle first-differing-bit finder: compares SCAN_W bits per cycle from bit 0
// upward and reports the index (or XLEN when equal) with a one-cycle done pulse.
module alu_seq_ctrl_diff_scanner #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned SCAN_W = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic [XLEN-1:0]             i_a,
    input  logic [XLEN-1:0]             i_b,
    output logic                        o_done,
    output logic [$clog2(XLEN+1)-1:0]   o_index
);

    localparam int unsigned NCHUNK = XLEN / SCAN_W;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned IW     = $clog2(XLEN + 1);

    logic          r_busy;
    logic [CW-1:0] r_chunk;
    logic          r_done;
    logic [IW-1:0] r_index;

    logic [XLEN-1:0]   w_x;
    logic [IW-1:0]     w_shift;
    logic [SCAN_W-1:0] w_chunk_bits;
    logic              w_hit;
    logic [IW-1:0]     w_pos;
    logic [IW-1:0]     w_base;
    logic              w_last;

    assign w_x          = i_a ^ i_b;
    assign w_base       = IW'(r_chunk) * IW'(SCAN_W);
    assign w_shift      = w_base;
    assign w_chunk_bits = SCAN_W'(w_x >> w_shift);
    assign w_last       = (r_chunk == CW'(NCHUNK - 1));

    // Lowest set bit of the current chunk wins
    always_comb begin
        w_hit = 1'b0;
        w_pos = '0;
        for (int i = int'(SCAN_W) - 1; i >= 0; i--) begin
            if (w_chunk_bits[i]) begin
                w_hit = 1'b1;
                w_pos = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_chunk <= '0;
            r_done  <= 1'b0;
            r_index <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_chunk <= '0;
            r_done  <= 1'b0;
        end else if (r_busy) begin
            if (w_hit) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_index <= w_base + w_pos;
            end else if (w_last) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_index <= IW'(XLEN);
            end else begin
                r_chunk <= r_chunk + CW'(1);
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_done  = r_done;
    assign o_index = r_index;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller in front of the combinational alu: one op per handshake,
// registered result, architectural flags, branch resolution and multi-cycle diff.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned SCAN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_seq_ctrl_if.slave    bus,
    output logic [FLGW-1:0]  flags_q,
    output logic [OPW-1:0]   alu_ctrl,
    output logic [XLEN-1:0]  alu_in1,
    output logic [XLEN-1:0]  alu_in2,
    output logic [XLEN-1:0]  alu_shamt,
    input  logic [XLEN-1:0]  alu_out,
    input  logic             alu_cout
);

    localparam int unsigned IW = $clog2(XLEN + 1);

    state_t          r_state, w_state_nxt;
    logic            r_op_ready, w_op_ready_nxt;
    logic            r_res_valid, w_res_valid_nxt;
    logic [XLEN-1:0] r_res_data, w_res_data_nxt;
    logic            r_br_taken, w_br_taken_nxt;
    logic [FLGW-1:0] r_flags, w_flags_nxt;

    logic [OPW-1:0]  r_op_code;
    logic [OPW-1:0]  r_alu_ctrl;
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [SHW-1:0]  r_shamt;

    logic            w_fire;
    logic            w_scan_start;
    logic            w_scan_done;
    logic [IW-1:0]   w_scan_index;

    alu_seq_ctrl_diff_scanner #(
        .XLEN   (XLEN),
        .SCAN_W (SCAN_W)
    ) u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_scan_start),
        .i_a     (r_op_a),
        .i_b     (r_op_b),
        .o_done  (w_scan_done),
        .o_index (w_scan_index)
    );

    // Next state, result, branch and flag updates
    always_comb begin
        w_state_nxt     = r_state;
        w_res_valid_nxt = r_res_valid;
        w_res_data_nxt  = r_res_data;
        w_br_taken_nxt  = r_br_taken;
        w_flags_nxt     = r_flags;
        w_fire          = 1'b0;
        w_scan_start    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_op_ready && bus.op_valid) begin
                    w_fire = 1'b1;
                    if (bus.op_code == OP_DIFF) begin
                        w_scan_start = 1'b1;
                        w_state_nxt  = ST_SCAN;
                    end else begin
                        w_state_nxt = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                w_state_nxt     = ST_DONE;
                w_res_valid_nxt = 1'b1;
                w_br_taken_nxt  = 1'b0;
                w_res_data_nxt  = alu_out;
                case (r_op_code)
                    OP_ADD, OP_COMP: begin
                        w_flags_nxt[FLG_NEG] = alu_out[XLEN-1];
                        w_flags_nxt[FLG_Z]   = ~|alu_out;
                        w_flags_nxt[FLG_NZ]  = |alu_out;
                        w_flags_nxt[FLG_CY]  = alu_cout;
                        w_flags_nxt[FLG_NCY] = ~alu_cout;
                    end
                    OP_BLTZ: begin
                        w_res_data_nxt = r_op_a;
                        w_br_taken_nxt = r_op_a[XLEN-1];
                    end
                    OP_BZ: begin
                        w_res_data_nxt = r_op_a;
                        w_br_taken_nxt = ~|r_op_a;
                    end
                    OP_BNZ: begin
                        w_res_data_nxt = r_op_a;
                        w_br_taken_nxt = |r_op_a;
                    end
                    OP_BCY: begin
                        w_res_data_nxt = r_op_a;
                        w_br_taken_nxt = r_flags[FLG_CY];
                    end
                    OP_BNCY: begin
                        w_res_data_nxt = r_op_a;
                        w_br_taken_nxt = r_flags[FLG_NCY];
                    end
                    default: begin
                        if (r_op_code > OP_DIFF) begin
                            w_res_data_nxt = '0;
                        end
                    end
                endcase
            end
            ST_SCAN: begin
                if (w_scan_done) begin
                    w_state_nxt     = ST_DONE;
                    w_res_valid_nxt = 1'b1;
                    w_res_data_nxt  = XLEN'(w_scan_index);
                    w_br_taken_nxt  = 1'b0;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_res_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_op_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_br_taken  <= 1'b0;
            r_flags     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_op_ready  <= w_op_ready_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_data  <= w_res_data_nxt;
            r_br_taken  <= w_br_taken_nxt;
            r_flags     <= w_flags_nxt;
        end
    end

    // Operand capture at accept; diff drives the alu in pass mode while scanning
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_code  <= '0;
            r_alu_ctrl <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_shamt    <= '0;
        end else if (w_fire) begin
            r_op_code  <= bus.op_code;
            r_alu_ctrl <= (bus.op_code == OP_DIFF) ? OP_PASS : bus.op_code;
            r_op_a     <= bus.op_a;
            r_op_b     <= bus.op_b;
            r_shamt    <= bus.op_shamt;
        end
    end

    assign bus.op_ready  = r_op_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.br_taken  = r_br_taken;
    assign flags_q       = r_flags;
    assign alu_ctrl      = r_alu_ctrl;
    assign alu_in1       = r_op_a;
    assign alu_in2       = r_op_b;
    assign alu_shamt     = XLEN'(r_shamt);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized + directed bench for alu_seq_ctrl with a behavioural alu and a
// reference model of results, branch decisions, flags and latency.
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned SCAN_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_seq_ctrl_if #(.XLEN(XLEN)) bus ();

    logic [4:0]  flags_q;
    logic [4:0]  alu_ctrl;
    logic [31:0] alu_in1, alu_in2, alu_shamt, alu_out;
    logic        alu_cout;
    logic [32:0] alu_res;

    alu_seq_ctrl #(.XLEN(XLEN), .SCAN_W(SCAN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flags_q   (flags_q),
        .alu_ctrl  (alu_ctrl),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_shamt (alu_shamt),
        .alu_out   (alu_out),
        .alu_cout  (alu_cout)
    );

    // Behavioural alu: {carry, result}
    function automatic logic [32:0] alu_fn(input logic [4:0] c, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] sh);
        case (c)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_COMP: return {1'b0, a} + {1'b0, ~b} + 33'd1;
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_NOR:  return {1'b0, ~(a | b)};
            OP_SLL:  return {1'b0, a << sh[4:0]};
            OP_SRL:  return {1'b0, a >> sh[4:0]};
            OP_SRA:  return {1'b0, 32'($signed(a) >>> sh[4:0])};
            OP_LUI:  return {1'b0, b << 16};
            default: return {1'b0, a};
        endcase
    endfunction

    assign alu_res  = alu_fn(alu_ctrl, alu_in1, alu_in2, alu_shamt);
    assign alu_out  = alu_res[31:0];
    assign alu_cout = alu_res[32];

    int n_total = 0;
    int n_bad   = 0;
    logic [4:0] m_flags = 5'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: result, branch, latency from the op rules; updates model flags
    task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] d, output logic br,
                         output int lat);
        logic [32:0] r;
        int idx;
        r   = alu_fn(op, a, b, 32'(sh));
        br  = 1'b0;
        lat = 2;
        d   = 32'd0;
        if (op == OP_DIFF) begin
            idx = XLEN;
            for (int i = XLEN - 1; i >= 0; i--) if (a[i] != b[i]) idx = i;
            d   = 32'(idx);
            lat = 2 + ((idx == XLEN) ? XLEN / SCAN_W : idx / SCAN_W + 1);
        end else if (op > OP_DIFF) begin
            d = 32'd0;
        end else if (op >= OP_BLTZ) begin
            d = a;
            case (op)
                OP_BLTZ: br = a[31];
                OP_BZ:   br = (a == 32'd0);
                OP_BNZ:  br = (a != 32'd0);
                OP_BCY:  br = m_flags[FLG_CY];
                default: br = m_flags[FLG_NCY];
            endcase
        end else begin
            d = r[31:0];
        end
        if (op == OP_ADD || op == OP_COMP) begin
            m_flags[FLG_NEG] = r[31];
            m_flags[FLG_Z]   = (r[31:0] == 32'd0);
            m_flags[FLG_NZ]  = (r[31:0] != 32'd0);
            m_flags[FLG_CY]  = r[32];
            m_flags[FLG_NCY] = ~r[32];
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input int hold);
        logic [31:0] ed;
        logic        eb;
        int          el;
        int          lat;
        int          guard;
        model(op, a, b, sh, ed, eb, el);
        @(negedge clk);
        guard = 0;
        while (!bus.op_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_rdy"}, 32'(bus.op_ready), 32'd1);
        bus.op_valid = 1'b1;
        bus.op_code  = op;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_shamt = sh;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        check_eq({tag, "_actl"}, 32'(alu_ctrl), 32'((op == OP_DIFF) ? OP_PASS : op));
        check_eq({tag, "_ain1"}, alu_in1, a);
        lat = 1;
        while (!bus.res_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(el));
        check_eq({tag, "_data"}, bus.res_data, ed);
        check_eq({tag, "_br"}, 32'(bus.br_taken), 32'(eb));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_hold_data"}, bus.res_data, ed);
            check_eq({tag, "_hold_ctl"}, {29'd0, bus.res_valid, bus.op_ready, bus.br_taken},
                     {29'd0, 1'b1, 1'b0, eb});
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        check_eq({tag, "_hs"}, {30'd0, bus.res_valid, bus.op_ready}, 32'd1);
        check_eq({tag, "_flags"}, 32'(flags_q), 32'(m_flags));
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;
        int          seen;
        rst_n         = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_code   = 5'd0;
        bus.op_a      = 32'd0;
        bus.op_b      = 32'd0;
        bus.op_shamt  = 5'd0;
        bus.res_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_ctl", {29'd0, bus.res_valid, bus.op_ready, bus.br_taken}, 32'd0);
        check_eq("rst_data", bus.res_data, 32'd0);
        check_eq("rst_flags", 32'(flags_q), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_rel_rdy", 32'(bus.op_ready), 32'd1);

        // Directed sequence
        run_op("add_ovf", OP_ADD, 32'hFFFF_FFFF, 32'h1, 5'd0, 0);
        check_eq("add_ovf_lit", 32'(flags_q), 32'h12);
        run_op("bcy_a", OP_BCY, 32'h0000_1234, 32'd0, 5'd0, 0);
        run_op("add_11", OP_ADD, 32'd1, 32'd1, 5'd0, 0);
        run_op("bncy", OP_BNCY, 32'h0000_0055, 32'd0, 5'd0, 0);
        run_op("bcy_b", OP_BCY, 32'h0000_0055, 32'd0, 5'd0, 0);
        run_op("diff8", OP_DIFF, 32'h0, 32'h0000_0100, 5'd0, 0);
        run_op("diff_eq", OP_DIFF, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 5'd0, 0);
        run_op("bp5", OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F, 5'd0, 5);
        run_op("bltz", OP_BLTZ, 32'h8000_0000, 32'd0, 5'd0, 0);
        run_op("bz", OP_BZ, 32'd0, 32'd7, 5'd0, 0);
        run_op("illegal", 5'b10101, 32'hDEAD_BEEF, 32'h1, 5'd3, 0);

        // Reset in the middle of a long diff scan
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_code  = OP_DIFF;
        bus.op_a     = 32'h0;
        bus.op_b     = 32'h8000_0000;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        m_flags = 5'd0;
        #1;
        check_eq("rmid_ctl", {29'd0, bus.res_valid, bus.op_ready, bus.br_taken}, 32'd0);
        check_eq("rmid_data", bus.res_data, 32'd0);
        check_eq("rmid_flags", 32'(flags_q), 32'd0);
        check_eq("rmid_alu", alu_in2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.res_valid) seen++;
        end
        check_eq("rmid_novalid", 32'(seen), 32'd0);

        // Randomized ops
        for (int n = 0; n < 80; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            op = (r < 17) ? 5'(r) : 5'($urandom_range(17, 31));
            a = $urandom;
            b = $urandom;
            if (op == OP_DIFF) begin
                case ($urandom_range(0, 2))
                    0: b = a;
                    1: b = a ^ (32'd1 << $urandom_range(0, 31));
                    default: ;
                endcase
            end else if (op >= OP_BLTZ && $urandom_range(0, 2) == 0) begin
                a = 32'd0;
            end else if (op <= OP_COMP && $urandom_range(0, 3) == 0) begin
                b = (op == OP_ADD) ? (32'd0 - a) : a;
            end
            run_op("rnd", op, a, b, 5'($urandom), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
